counter_16bit_ctrl: RTL and testbench
=====================================

# counter_16bit_ctrl

Sequencing controller for the 16-bit up-counter (`top`: `clk`, `reset`, `enable`, `count`). It drives the counter's synchronous `reset`/`enable` and watches `count` to build a programmable interval timer: one-shot or periodic, with a prescaler and a terminal-count pulse. It sits beside the counter at the top level. Software-style control arrives as single-cycle `start`/`stop` pulses.

## Interface
- `CNT_W`, 16: counter width; must match the counter.
- `PRE_W`, 8: prescaler width.
- `PER_W`, 8: completed-period counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: pulse; arms the timer from IDLE.
- `stop` in 1: pulse; aborts the run.
- `mode` in 1: 0 = one-shot, 1 = periodic. Latched at start.
- `limit` in CNT_W: terminal count value. Latched at start.
- `prescale` in PRE_W: counter advances once every `prescale`+1 cycles. Latched at start.
- `count` in CNT_W: counter output.
- `cnt_reset` out 1: to counter `reset`.
- `cnt_enable` out 1: to counter `enable`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse per terminal event.
- `periods` out PER_W: terminal events since the last start; saturates.
- `fault` out 1: sticky; `count` exceeded the latched limit.

## Operation
States: IDLE, RUN.
- **Outputs by state.** `cnt_reset` and `cnt_enable` are combinational from the registered state, the prescaler `pre_q` and `count`.
  - IDLE: `cnt_reset`=1, `cnt_enable`=0.
  - RUN: `cnt_reset`=`term`, `cnt_enable`=`tick` & !`term`.
- **Signals.**
  - `tick` = RUN & (`pre_q` == `prescale_q`).
  - `term` = `tick` & (`count` == `limit_q`).
- **IDLE.**
  - `start` & !`stop`: latch `limit`, `prescale` and `mode`; clear `pre_q`, `periods` and `fault`; go to RUN.
  - `start` & `stop` together: stay in IDLE.
- **RUN, in priority order:**
  1. `stop`: go to IDLE; no `done`, even if `term` is high the same cycle.
  2. `count` > `limit_q`: set `fault`, go to IDLE.
  3. `term`: `done` high the next cycle; `periods` increments, saturating at all-ones. One-shot goes to IDLE; periodic stays in RUN.
- **Prescaler.** `pre_q` wraps to 0 on `tick`, otherwise increments. Held at 0 in IDLE.
- **Ignored input.** `start` in RUN is ignored; latched values are unchanged.
- **Period.** The counter visits 0..`limit_q`, holding each value `prescale_q`+1 cycles. Period is (`limit_q`+1)·(`prescale_q`+1) cycles.
- **`limit`=0.** `term` fires on every `tick`.

## Timing
- **Reset values.** State IDLE, `pre_q`=0, `cnt_reset`=1, `cnt_enable`=0, `busy`=0, `done`=0, `periods`=0, `fault`=0. Latched registers are 0.
- **Asynchronous reset mid-run** returns to IDLE immediately; no `done`.
- **Start latency.** `start` is sampled at edge N; RUN and `busy` are in effect from edge N. With `prescale`=0, `cnt_enable` is high in the first RUN cycle and `count`=1 after edge N+1.
- **Terminal timing.** `term` is high in cycle T; the counter reads 0 after edge T+1. `done` is registered: high from edge T+1 for exactly one cycle.
- **One-shot end.** `busy` falls at edge T+1, coincident with `done`.
- **Stop.** `busy` falls at the edge after `stop` is sampled. `cnt_reset` is high from the next cycle.
- **Re-arm.** A `start` in the cycle after a one-shot `done` re-arms. No dead cycle is required.

## Structure
- **Package `counter_ctrl_pkg`:** state enum (IDLE, RUN) and mode constants (`MODE_ONESHOT`=0, `MODE_PERIODIC`=1).
- **Sub-module `counter_prescaler`:** holds `pre_q`; inputs `clear` and `load_val`; outputs `tick`.
- **Top level of the block:** FSM, latches, `periods` and `fault` logic. The counter itself stays external.

## Test plan
- **One-shot:** `limit`=4, `prescale`=0, `mode`=0, `start` at cycle 10 → `count` 0,1,2,3,4 then 0; `done` single pulse at cycle 15; `busy` low from cycle 15; `periods`=1.
- **Periodic with prescaler:** `limit`=2, `prescale`=3, `mode`=1 → `done` every 12 cycles; each `count` value held 4 cycles; after 300 periods `periods`=255.
- **Stop collision:** periodic run, `stop` asserted in the same cycle as `term` → no `done`; IDLE next cycle; `count`=0; `periods` unchanged.
- **Edge limits:** `limit`=0, `prescale`=0 → `done` every cycle after the first; `count` stays 0. Separately `limit`=16'hFFFF, `prescale`=0 → first `done` 65536 cycles after start; no overflow.
- **Fault:** force the counter `count` to `limit`+1 mid-run → `fault`=1; IDLE next cycle; next `start` clears `fault`.
- **Async reset mid-run:** assert `reset` between edges during RUN → all outputs immediately at reset values; `start`/`stop` pulses in the same cycle are ignored.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the interval-timer controller that sequences
// the external 16-bit up-counter.
package counter_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for the interval timer: emits one tick every load_val+1 cycles
// while running, and is held at zero while clear is asserted.
module counter_prescaler #(
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [PRE_W-1:0] load_val,
  output logic             tick
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Tick on the last count of each prescale window; wrap there, else advance.
  always_comb begin
    tick  = !clear && (pre_q == load_val);
    pre_d = pre_q + 1'b1;
    if (clear || tick) begin
      pre_d = '0;
    end
  end

  // Prescale count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_16bit_ctrl.sv
// Interval-timer controller for the external 16-bit up-counter: drives the
// counter's synchronous reset/enable, watches its count, and reports terminal
// events (one-shot or periodic) with a saturating period count and a sticky
// over-limit fault.
module counter_16bit_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8,
  parameter int unsigned PER_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] count,
  output logic             cnt_reset,
  output logic             cnt_enable,
  output logic             busy,
  output logic             done,
  output logic [PER_W-1:0] periods,
  output logic             fault
);

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] limit_q,    limit_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             mode_q,     mode_d;
  logic [PER_W-1:0] periods_q,  periods_d;
  logic             fault_q,    fault_d;
  logic             done_q,     done_d;

  logic run;
  logic tick;
  logic term;

  assign run = (state_q == RUN);

  counter_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (!run),
    .load_val(prescale_q),
    .tick    (tick)
  );

  // Counter control: hold the counter cleared in IDLE, wrap it at terminal count.
  always_comb begin
    term       = tick && (count == limit_q);
    cnt_reset  = 1'b1;
    cnt_enable = 1'b0;
    if (run) begin
      cnt_reset  = term;
      cnt_enable = tick && !term;
    end
  end

  // Next-state logic: arming, stop/fault aborts, terminal-event bookkeeping.
  always_comb begin
    state_d    = state_q;
    limit_d    = limit_q;
    prescale_d = prescale_q;
    mode_d     = mode_q;
    periods_d  = periods_q;
    fault_d    = fault_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          limit_d    = limit;
          prescale_d = prescale;
          mode_d     = mode;
          periods_d  = '0;
          fault_d    = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // stop outranks a same-cycle terminal event, so no done is produced.
        if (stop) begin
          state_d = IDLE;
        end else if (count > limit_q) begin
          fault_d = 1'b1;
          state_d = IDLE;
        end else if (term) begin
          done_d = 1'b1;
          if (periods_q != '1) begin
            periods_d = periods_q + 1'b1;
          end
          if (mode_q != MODE_PERIODIC) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      limit_q    <= '0;
      prescale_q <= '0;
      mode_q     <= MODE_ONESHOT;
      periods_q  <= '0;
      fault_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      limit_q    <= limit_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      periods_q  <= periods_d;
      fault_q    <= fault_d;
      done_q     <= done_d;
    end
  end

  assign busy    = run;
  assign done    = done_q;
  assign periods = periods_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_counter_16bit_ctrl.sv
// Directed bench for counter_16bit_ctrl with a behavioural model of the
// external 16-bit up-counter closing the loop.
module tb_counter_16bit_ctrl;
  import counter_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] limit = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] count;
  logic        cnt_reset;
  logic        cnt_enable;
  logic        busy;
  logic        done;
  logic [7:0]  periods;
  logic        fault;

  logic [15:0] cnt = '0;
  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  // External counter model: synchronous reset, enable-gated increment.
  always @(posedge clk) begin
    if (cnt_reset) cnt <= '0;
    else if (cnt_enable) cnt <= cnt + 16'd1;
  end

  assign count = force_en ? force_val : cnt;

  counter_16bit_ctrl #(
    .CNT_W(16),
    .PRE_W(8),
    .PER_W(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .limit     (limit),
    .prescale  (prescale),
    .count     (count),
    .cnt_reset (cnt_reset),
    .cnt_enable(cnt_enable),
    .busy      (busy),
    .done      (done),
    .periods   (periods),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic m, input logic [15:0] lim, input logic [7:0] pre);
    mode = m; limit = lim; prescale = pre; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int unsigned g;
    int unsigned bad;

    // Asynchronous reset at power-up.
    #1 reset = 1'b1;
    #2;
    check("rst_cnt_reset", cnt_reset, 1);
    check("rst_cnt_enable", cnt_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_periods", periods, 0);
    check("rst_fault", fault, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // One-shot: limit 4, prescale 0.
    arm(MODE_ONESHOT, 16'd4, 8'd0);
    check("os_busy0", busy, 1);
    check("os_en0", cnt_enable, 1);
    check("os_cnt0", count, 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("os_cnt", count, k);
      check("os_nodone", done, 0);
    end
    check("os_term", cnt_reset, 1);
    step();
    check("os_wrap", count, 0);
    check("os_done", done, 1);
    check("os_busy_end", busy, 0);
    check("os_periods", periods, 1);

    // Re-arm in the cycle carrying done.
    arm(MODE_ONESHOT, 16'd1, 8'd0);
    check("rearm_busy", busy, 1);
    check("rearm_periods", periods, 0);
    check("rearm_cnt", count, 0);
    step();
    check("rearm_cnt1", count, 1);
    step();
    check("rearm_done", done, 1);
    check("rearm_periods1", periods, 1);
    check("rearm_idle", busy, 0);
    step();
    check("done_one_cycle", done, 0);

    // Periodic: limit 2, prescale 3 -> 12-cycle period, each value held 4 cycles.
    arm(MODE_PERIODIC, 16'd2, 8'd3);
    for (int k = 0; k < 12; k++) begin
      check("per_seq", count, k / 4);
      check("per_seq_nodone", done, 0);
      if (k != 11) step();
    end
    step();
    check("per_done1", done, 1);
    check("per_cnt_wrap", count, 0);
    // A start while running must not relatch anything.
    limit = 16'd7; prescale = 8'd0; mode = MODE_ONESHOT; start = 1'b1;
    bad = 0;
    for (int p = 1; p < 300; p++) begin
      g = 0;
      do begin
        step();
        start = 1'b0;
        g++;
      end while (!done && g < 20);
      if (g != 12) bad++;
    end
    check("per_gap", bad, 0);
    check("per_sat", periods, 255);
    check("per_busy", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("per_stopped", busy, 0);

    // Stop in the same cycle as term.
    arm(MODE_PERIODIC, 16'd2, 8'd0);
    step(); step(); step();
    check("sc_done1", done, 1);
    check("sc_periods1", periods, 1);
    step(); step();
    check("sc_term", cnt_reset, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("sc_nodone", done, 0);
    check("sc_idle", busy, 0);
    check("sc_cnt", count, 0);
    check("sc_periods", periods, 1);
    check("sc_cnt_reset", cnt_reset, 1);

    // limit 0: term on every tick.
    arm(MODE_PERIODIC, 16'd0, 8'd0);
    check("l0_first_nodone", done, 0);
    check("l0_term0", cnt_reset, 1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done !== 1'b1 || count !== 16'd0) bad++;
    end
    check("l0_every_cycle", bad, 0);
    check("l0_periods", periods, 10);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // limit all-ones: full 65536-cycle period, no overflow.
    arm(MODE_ONESHOT, 16'hFFFF, 8'd0);
    g = 0;
    do begin
      step();
      g++;
    end while (!done && g < 70000);
    check("lmax_latency", g, 65536);
    check("lmax_cnt", count, 0);
    check("lmax_periods", periods, 1);
    check("lmax_idle", busy, 0);
    step();

    // Fault: count forced past the latched limit.
    arm(MODE_PERIODIC, 16'd5, 8'd1);
    step(); step(); step();
    force_val = 16'd6;
    force_en = 1'b1;
    step();
    check("flt_set", fault, 1);
    check("flt_idle", busy, 0);
    check("flt_nodone", done, 0);
    check("flt_cnt_reset", cnt_reset, 1);
    force_en = 1'b0;
    step();
    check("flt_sticky", fault, 1);
    arm(MODE_PERIODIC, 16'd5, 8'd1);
    check("flt_clear", fault, 0);
    check("flt_rerun", busy, 1);

    // Async reset mid-run with start/stop held.
    g = 0;
    do begin
      step();
      g++;
    end while (!done && g < 40);
    check("ar_done_seen", done, 1);
    check("ar_periods", periods, 1);
    #2;
    reset = 1'b1; start = 1'b1; stop = 1'b1;
    #1;
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    check("ar_cnt_reset", cnt_reset, 1);
    check("ar_cnt_enable", cnt_enable, 0);
    check("ar_periods0", periods, 0);
    check("ar_fault", fault, 0);
    step();
    check("ar_start_ignored", busy, 0);
    reset = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    check("ar_stays_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
